// File: rtl/melody_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : melody_seq_ctrl
// Description : APB slave that stores up to DEPTH notes (tone code + duration
//               in ms) and plays them in order on tone_sel, one duration tick
//               every TICK_DIV clocks. Looping is optional. A one-cycle
//               seq_done pulse marks the end of a non-looping melody.
// Ports       : PCLK/PRESET      - clock, asynchronous active-high reset
//               PADDR..PSEL      - APB slave request (PADDR[3:2] = register)
//               PRDATA, PREADY   - registered APB response (one wait state)
//               tone_sel         - tone code to tone ROM, 4'hF = silence
//               seq_done         - end-of-melody pulse
// Registers   : 0x0 CTRL, 0x4 NOTE, 0x8 STATUS, 0xC REMAIN
// Revision    : 1.0 - initial release
// ============================================================================
module melody_seq_ctrl #(
  parameter int DEPTH    = 16,      // power of 2, at most 16 (STATUS fields)
  parameter int TICK_DIV = 100_000  // PCLK cycles per 1 ms tick, at least 2
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic [3:0]  tone_sel,
  output logic        seq_done
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [3:0]    SILENCE    = 4'hF;
  localparam logic [1:0]    A_CTRL     = 2'd0;
  localparam logic [1:0]    A_NOTE     = 2'd1;
  localparam logic [1:0]    A_STATUS   = 2'd2;
  localparam logic [1:0]    A_REMAIN   = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count;
  logic [IW-1:0] idx, idx_nxt, idx_inc;
  logic [11:0]   remain, remain_nxt;
  logic [TW-1:0] tick, tick_nxt;
  logic [3:0]    tone_nxt;
  logic          done_nxt;
  logic          loop;
  logic          adv;
  logic [15:0]   mem [DEPTH];   // {dur_ms[11:0], tone[3:0]}, not reset
  logic [15:0]   cur_note;
  logic [CW-1:0] idx_ext_inc;
  logic          last_note;
  logic [31:0]   rdata;

  // The commit cycle of a transfer is the one where PREADY is about to rise.
  logic access, wr, rd;
  logic ctrl_wr, start, stop, note_wr, clr_wr, idle, full;

  assign access  = PSEL & PENABLE & ~PREADY;
  assign wr      = access & PWRITE;
  assign rd      = access & ~PWRITE;
  assign idle    = (state == IDLE);
  assign full    = (count == FULL_COUNT);
  assign ctrl_wr = wr & (PADDR[3:2] == A_CTRL);
  assign start   = ctrl_wr & PWDATA[0];
  assign stop    = ctrl_wr & PWDATA[1];
  assign note_wr = wr & (PADDR[3:2] == A_NOTE) & idle & ~full;
  assign clr_wr  = wr & (PADDR[3:2] == A_STATUS) & PWDATA[0] & idle;

  assign cur_note    = mem[idx];
  assign idx_inc     = idx + 1'b1;
  assign idx_ext_inc = {1'b0, idx} + CW'(1);
  assign last_note   = (idx_ext_inc >= count);   // i.e. not (idx < count-1)

  logic unused_bits;
  assign unused_bits = ^{PADDR[1:0], PWDATA[31:16]};

  // tone_sel is loaded on every transition into LOAD, so a note is visible
  // for its LOAD cycle plus its PLAY cycles (a zero-duration note shows for
  // exactly one cycle).
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    remain_nxt = remain;
    tick_nxt   = tick;
    tone_nxt   = tone_sel;
    done_nxt   = 1'b0;
    adv        = 1'b0;

    case (state)
      LOAD: begin
        remain_nxt = cur_note[15:4];
        tick_nxt   = '0;
        if (cur_note[15:4] == 12'd0) adv = 1'b1;
        else                         state_nxt = PLAY;
      end
      PLAY: begin
        if (tick == TICK_LAST) begin
          tick_nxt = '0;
          if (remain == 12'd1) adv = 1'b1;
          else                 remain_nxt = remain - 12'd1;
        end else begin
          tick_nxt = tick + 1'b1;
        end
      end
      default: ;
    endcase

    if (adv) begin
      if (!last_note) begin
        idx_nxt   = idx_inc;
        state_nxt = LOAD;
        tone_nxt  = mem[idx_inc][3:0];
      end else if (loop) begin
        idx_nxt   = '0;
        state_nxt = LOAD;
        tone_nxt  = mem[0][3:0];
      end else begin
        state_nxt = IDLE;
        tone_nxt  = SILENCE;
        done_nxt  = 1'b1;
      end
    end

    // Software commands override sequencing; STOP beats START.
    if (stop) begin
      state_nxt = IDLE;
      tone_nxt  = SILENCE;
      done_nxt  = 1'b0;
      idx_nxt   = idx;
    end else if (start && (!idle || count != '0)) begin
      idx_nxt   = '0;
      state_nxt = LOAD;
      tone_nxt  = mem[0][3:0];
      done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state    <= IDLE;
      idx      <= '0;
      remain   <= '0;
      tick     <= '0;
      tone_sel <= SILENCE;
      seq_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      remain   <= remain_nxt;
      tick     <= tick_nxt;
      tone_sel <= tone_nxt;
      seq_done <= done_nxt;
    end
  end

  always_comb begin
    rdata = '0;
    case (PADDR[3:2])
      A_CTRL:   rdata[2] = loop;
      A_STATUS: begin
        rdata[8 +: CW] = count;
        rdata[4 +: IW] = idx;
        rdata[1]       = full;
        rdata[0]       = ~idle;
      end
      A_REMAIN: if (!idle) rdata[11:0] = remain;
      default:  ;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PREADY <= 1'b0;
      PRDATA <= '0;
      count  <= '0;
      loop   <= 1'b0;
    end else begin
      PREADY <= access;
      if (rd)           PRDATA <= rdata;
      if (ctrl_wr)      loop   <= PWDATA[2];
      if (clr_wr)       count  <= '0;
      else if (note_wr) count  <= count + 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (note_wr) mem[count[IW-1:0]] <= PWDATA[15:0];
  end

endmodule
`default_nettype wire

// File: tb/tb_melody_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_melody_seq_ctrl
// Description : Directed self-checking bench for melody_seq_ctrl with
//               DEPTH=16 and TICK_DIV=10. Inputs change on the falling edge,
//               outputs are sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_melody_seq_ctrl;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [3:0]  PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE, PENABLE, PSEL;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic [3:0]  tone_sel;
  logic        seq_done;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  localparam logic [3:0] CTRL = 4'h0, NOTE = 4'h4, STATUS = 4'h8, REMAIN = 4'hC;

  melody_seq_ctrl #(.DEPTH(16), .TICK_DIV(10)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PENABLE(PENABLE), .PSEL(PSEL), .PRDATA(PRDATA),
    .PREADY(PREADY), .tone_sel(tone_sel), .seq_done(seq_done)
  );

  always #5 PCLK = ~PCLK;

  always @(negedge PCLK) if (seq_done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the commit.
  task automatic apb_xfer(input logic wr, input logic [3:0] a, input logic [31:0] d,
                          output logic [31:0] rd);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
    @(negedge PCLK);
    check("pready_setup", {31'b0, PREADY}, 32'd0);
    PENABLE = 1'b1;
    @(negedge PCLK);
    check("pready_wait1", {31'b0, PREADY}, 32'd1);
    rd = PRDATA;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    apb_xfer(1'b1, a, d, dummy);
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [31:0] d);
    apb_xfer(1'b0, a, 32'd0, d);
  endtask

  // Counts consecutive falling-edge samples showing tone t, bounded by limit.
  task automatic run_len(input logic [3:0] t, input int limit, output int n);
    n = 0;
    while (tone_sel === t && n < limit) begin
      n++;
      @(negedge PCLK);
    end
  endtask

  initial begin
    logic [31:0] rv;
    int n;

    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0;
    repeat (3) @(negedge PCLK);
    check("rst_tone", {28'b0, tone_sel}, 32'hF);
    check("rst_pready", {31'b0, PREADY}, 32'd0);
    check("rst_done", {31'b0, seq_done}, 32'd0);
    check("rst_prdata", PRDATA, 32'd0);
    PRESET = 1'b0;
    @(negedge PCLK);
    apb_read(STATUS, rv);
    check("rst_status", rv, 32'h0000_0000);

    // Two-note melody, single pass
    apb_write(NOTE, 32'h30);            // tone 0, 3 ms
    apb_write(NOTE, 32'h27);            // tone 7, 2 ms
    apb_read(STATUS, rv);
    check("status_cnt2", rv, 32'h0000_0200);
    apb_write(CTRL, 32'h1);
    run_len(4'h0, 200, n);
    check("run_tone0", n, 31);
    run_len(4'h7, 200, n);
    check("run_tone7", n, 21);
    check("end_tone", {28'b0, tone_sel}, 32'hF);
    check("done_pulse", {31'b0, seq_done}, 32'd1);
    @(negedge PCLK);
    check("done_one_cycle", {31'b0, seq_done}, 32'd0);
    apb_read(STATUS, rv);
    check("status_after_play", rv, 32'h0000_0210);

    // Looping, then STOP in the middle of note 7
    apb_write(CTRL, 32'h4);
    apb_read(CTRL, rv);
    check("ctrl_loop_rd", rv, 32'h0000_0004);
    apb_write(CTRL, 32'h5);
    run_len(4'h0, 200, n);
    check("loop_run0a", n, 31);
    run_len(4'h7, 200, n);
    check("loop_run7a", n, 21);
    run_len(4'h0, 200, n);
    check("loop_run0b", n, 31);
    repeat (3) @(negedge PCLK);
    apb_write(CTRL, 32'h2);
    check("stop_tone", {28'b0, tone_sel}, 32'hF);
    apb_read(STATUS, rv);
    check("stop_status", rv, 32'h0000_0210);
    apb_read(CTRL, rv);
    check("ctrl_loop_clr", rv, 32'h0000_0000);
    check("loop_no_done", done_cnt, 1);

    // Fill memory past DEPTH, zero-duration note skipped
    apb_write(STATUS, 32'h1);
    apb_read(STATUS, rv);
    check("clr_count", rv, 32'h0000_0010);
    apb_write(NOTE, 32'h13);            // tone 3, 1 ms
    apb_write(NOTE, 32'h05);            // tone 5, 0 ms
    apb_write(NOTE, 32'h19);            // tone 9, 1 ms
    for (int i = 0; i < 13; i++) apb_write(NOTE, 32'h1C);  // rests, 1 ms
    apb_write(NOTE, 32'h1A);            // 17th entry, dropped
    apb_read(STATUS, rv);
    check("status_full", rv, 32'h0000_1012);
    apb_write(CTRL, 32'h1);
    run_len(4'h3, 200, n);
    check("full_run3", n, 11);
    run_len(4'h5, 200, n);
    check("skip_run5", n, 1);
    run_len(4'h9, 200, n);
    check("full_run9", n, 11);
    run_len(4'hC, 400, n);
    check("full_runC", n, 143);
    check("full_end_tone", {28'b0, tone_sel}, 32'hF);
    check("full_done", {31'b0, seq_done}, 32'd1);

    // START with an empty memory
    @(negedge PCLK);
    apb_write(STATUS, 32'h1);
    apb_write(CTRL, 32'h1);
    repeat (3) @(negedge PCLK);
    check("empty_tone", {28'b0, tone_sel}, 32'hF);
    apb_read(STATUS, rv);
    check("empty_status", rv, 32'h0000_00F0);
    check("empty_no_done", done_cnt, 2);

    // START+STOP together, then writes that must be ignored while busy
    apb_write(NOTE, 32'h30);
    apb_write(NOTE, 32'h27);
    apb_write(CTRL, 32'h1);
    repeat (4) @(negedge PCLK);
    apb_write(CTRL, 32'h3);
    check("startstop_tone", {28'b0, tone_sel}, 32'hF);
    apb_read(STATUS, rv);
    check("startstop_status", rv, 32'h0000_0200);
    apb_write(CTRL, 32'h1);
    apb_write(NOTE, 32'h11);
    apb_write(STATUS, 32'h1);
    apb_read(STATUS, rv);
    check("busy_writes_ignored", rv, 32'h0000_0201);
    apb_write(CTRL, 32'h2);

    // Asynchronous reset mid-play
    apb_write(CTRL, 32'h1);
    repeat (13) @(negedge PCLK);
    apb_read(REMAIN, rv);
    check("remain_2", rv, 32'h0000_0002);
    check("playing_tone0", {28'b0, tone_sel}, 32'h0);
    PRESET = 1'b1;
    #1;
    check("async_rst_tone", {28'b0, tone_sel}, 32'hF);
    check("async_rst_prdata", PRDATA, 32'd0);
    check("async_rst_pready", {31'b0, PREADY}, 32'd0);
    check("async_rst_done", {31'b0, seq_done}, 32'd0);
    @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
    apb_read(STATUS, rv);
    check("post_rst_status", rv, 32'h0000_0000);
    apb_write(CTRL, 32'h1);
    repeat (3) @(negedge PCLK);
    check("post_rst_tone", {28'b0, tone_sel}, 32'hF);
    apb_read(STATUS, rv);
    check("post_rst_idle", rv, 32'h0000_0000);
    check("total_done", done_cnt, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
